// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block, read-only instruction cache.
// Fetches that hit are answered in the same cycle. On a miss, the cache
// fetches the word from the instruction RAM port, then overwrites the line.
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - 2 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state, next_state;

    logic [31:0]      miss_addr;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS];

    logic [TAG_W-1:0] cur_tag;
    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic             fill;
    logic             unused_addr_bits;

    // Byte-offset bits of the fetch address play no part in a word cache.
    assign unused_addr_bits = ^imemaddr[1:0];

    assign cur_tag  = imemaddr[31:2+IDX_W];
    assign cur_idx  = imemaddr[1+IDX_W:2];
    assign miss_tag = miss_addr[31:2+IDX_W];
    assign miss_idx = miss_addr[1+IDX_W:2];
    assign fill     = (state == FETCH) && !iwait;

    // Hit detection, fetch-side outputs and next-state selection.
    always_comb begin
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        next_state = state;
        case (state)
            IDLE: begin
                if (imemREN && valid[cur_idx] && (tag_arr[cur_idx] == cur_tag)) begin
                    ihit     = 1'b1;
                    imemload = data_arr[cur_idx];
                end else if (imemREN) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, captured miss address and valid bits; reset clears every line.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= 32'h0;
            valid     <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && (next_state == FETCH)) begin
                miss_addr <= {imemaddr[31:2], 2'b00};
            end
            if (fill) begin
                valid[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage; written only by a completed fill, never reset.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_arr[miss_idx]  <= miss_tag;
            data_arr[miss_idx] <= iload;
        end
    end

endmodule
